dm_requester: RTL and testbench

- Initiator side of the data-memory (DM) port. Accepts tagged load/store requests from the core through a valid/ready queue.
- Drives the DM control, address and data lines with the memory's exact timing: store data is presented one cycle after issue, and load data is sampled one cycle after issue.
- Returns tagged load responses. Sits between the data-address generator/core and the memory block.

---
 rtl/dm_requester_if.sv | 42 ++++
 rtl/dm_requester.sv | 134 +++++++++++++
 tb/tb_dm_requester.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_requester_if.sv
//------------------------------------------------------------------------------
// Module : dm_requester_if
// Brief  : Core request/response channel and DM bus lines of dm_requester.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dm_requester_if #(
  parameter int DMA_SIZE = 17,
  parameter int DMD_SIZE = 16,
  parameter int TAG_W    = 4
);
  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [DMA_SIZE-1:0] req_addr;
  logic [DMD_SIZE-1:0] req_wdata;
  logic [TAG_W-1:0]    req_tag;
  logic                rsp_valid;
  logic [DMD_SIZE-1:0] rsp_data;
  logic [TAG_W-1:0]    rsp_tag;
  logic                busy;
  logic                ps_dm_cslt;
  logic                ps_dm_wrb;
  logic [DMA_SIZE-1:0] dg_dm_add;
  logic [DMD_SIZE-1:0] bc_dt;
  logic [DMD_SIZE-1:0] dm_bc_dt;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_tag, dm_bc_dt,
    output req_ready, rsp_valid, rsp_data, rsp_tag, busy,
           ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_tag, dm_bc_dt,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, busy,
           ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt
  );
endinterface

`default_nettype wire

// File: rtl/dm_requester.sv
//------------------------------------------------------------------------------
// Module : dm_requester
// Brief  : Queued tagged load/store initiator for the DM port with bypass guard.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_requester #(
  parameter int DMA_SIZE   = 17,
  parameter int DMD_SIZE   = 16,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  dm_requester_if.slave bus
);

  localparam int              c_PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_CW   = c_PW + 1;
  localparam int              c_EW   = 1 + DMA_SIZE + DMD_SIZE + TAG_W;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

  logic [c_EW-1:0]     r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]     r_wptr, r_rptr;
  logic [c_CW-1:0]     r_count;

  logic                r_cslt, r_wrb;
  logic [DMA_SIZE-1:0] r_add;
  logic [DMD_SIZE-1:0] r_st_d1, r_bc;
  logic                r_st2, r_ld2;
  logic [TAG_W-1:0]    r_tag1, r_tag2;
  logic                r_rsp_v;
  logic [DMD_SIZE-1:0] r_rsp_d;
  logic [TAG_W-1:0]    r_rsp_t;

  logic                w_ready, w_push, w_pop, w_bubble, w_hazard, w_nonempty;
  logic                w_st1, w_ld1;
  logic [c_EW-1:0]     w_head;
  logic                w_h_wr;
  logic [DMA_SIZE-1:0] w_h_addr;
  logic [DMD_SIZE-1:0] w_h_data;
  logic [TAG_W-1:0]    w_h_tag;

  assign w_ready    = (r_count != c_FULL);
  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.req_valid & w_ready;

  assign w_head   = r_mem[r_rptr];
  assign w_h_wr   = w_head[c_EW-1];
  assign w_h_addr = w_head[c_EW-2 -: DMA_SIZE];
  assign w_h_data = w_head[DMD_SIZE+TAG_W-1 -: DMD_SIZE];
  assign w_h_tag  = w_head[TAG_W-1:0];

  // Phase-1 flags are exactly the access currently on the DM bus.
  assign w_st1 = r_cslt & r_wrb;
  assign w_ld1 = r_cslt & ~r_wrb;

  // The memory bypasses on a repeated address unless the prior cycle issued a store.
  assign w_hazard = ~w_h_wr & (r_add == w_h_addr) & ~w_st1;
  assign w_pop    = w_nonempty & ~w_hazard;
  assign w_bubble = w_nonempty & w_hazard;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.req_wr, bus.req_addr, bus.req_wdata, bus.req_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + c_CW'(1);
      else if (~w_push & w_pop) r_count <= r_count - c_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cslt  <= 1'b0;
      r_wrb   <= 1'b0;
      r_add   <= '0;
      r_st_d1 <= '0;
      r_tag1  <= '0;
    end else begin
      r_cslt <= w_pop;
      r_wrb  <= w_pop & w_h_wr;
      if (w_pop)         r_add <= w_h_addr;
      else if (w_bubble) r_add <= ~w_h_addr;
      if (w_pop & w_h_wr) r_st_d1 <= w_h_data;
      if (w_pop)          r_tag1  <= w_h_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st2   <= 1'b0;
      r_bc    <= '0;
      r_ld2   <= 1'b0;
      r_tag2  <= '0;
      r_rsp_v <= 1'b0;
      r_rsp_d <= '0;
      r_rsp_t <= '0;
    end else begin
      r_st2 <= w_st1;
      if (w_st1) r_bc <= r_st_d1;
      r_ld2  <= w_ld1;
      r_tag2 <= r_tag1;
      r_rsp_v <= r_ld2;
      if (r_ld2) begin
        r_rsp_d <= bus.dm_bc_dt;
        r_rsp_t <= r_tag2;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.ps_dm_cslt = r_cslt;
  assign bus.ps_dm_wrb  = r_wrb;
  assign bus.dg_dm_add  = r_add;
  assign bus.bc_dt      = r_bc;
  assign bus.rsp_valid  = r_rsp_v;
  assign bus.rsp_data   = r_rsp_d;
  assign bus.rsp_tag    = r_rsp_t;
  assign bus.busy       = w_nonempty | r_cslt | r_st2 | r_ld2;

endmodule

`default_nettype wire

// File: tb/tb_dm_requester.sv
//------------------------------------------------------------------------------
// Module : tb_dm_requester
// Brief  : Randomised and directed bench for dm_requester with a transaction model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_requester;
  localparam int DMA = 17;
  localparam int DMD = 16;
  localparam int TW  = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_requester_if #(.DMA_SIZE(DMA), .DMD_SIZE(DMD), .TAG_W(TW)) bus ();

  dm_requester #(.DMA_SIZE(DMA), .DMD_SIZE(DMD), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] init_val(input logic [16:0] a);
    return {a[7:0] ^ 8'hA5, a[7:0]};
  endfunction

  // Synchronous DM with write-to-read bypass; content is idle junk outside reads.
  logic [15:0] pmem [0:511];
  logic        p_wpend;
  logic [16:0] p_waddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) pmem[i] <= init_val(17'(i));
      p_wpend      <= 1'b0;
      p_waddr      <= '0;
      bus.dm_bc_dt <= '0;
    end else begin
      if (p_wpend) pmem[p_waddr[8:0]] <= bus.bc_dt;
      p_wpend <= bus.ps_dm_cslt & bus.ps_dm_wrb;
      p_waddr <= bus.dg_dm_add;
      if (bus.ps_dm_cslt & ~bus.ps_dm_wrb)
        bus.dm_bc_dt <= (p_wpend && p_waddr == bus.dg_dm_add) ? bus.bc_dt : pmem[bus.dg_dm_add[8:0]];
      else
        bus.dm_bc_dt <= 16'($urandom);
    end
  end

  // Transaction model: request queue, in-order issue with the bypass guard,
  // and scheduled visibility of store data and load responses.
  typedef struct packed {
    logic        wr;
    logic [16:0] addr;
    logic [15:0] data;
    logic [3:0]  tag;
  } req_t;
  typedef struct {
    int          when;
    logic        is_ld;
    logic [16:0] addr;
    logic [15:0] data;
    logic [3:0]  tag;
  } ev_t;

  req_t        mq[$];
  ev_t         evq[$];
  logic [15:0] mmem [int];
  int          m_cyc = 0;
  logic        m_cslt = 0, m_wrb = 0, m_rvalid = 0, m_busy = 0, m_ready = 1;
  logic [16:0] m_add = '0;
  logic [15:0] m_bc = '0, m_rdata = '0;
  logic [3:0]  m_rtag = '0;

  function automatic logic [15:0] mread(input logic [16:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : init_val(a);
  endfunction

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); evq.delete(); mmem.delete();
        m_cslt = 0; m_wrb = 0; m_add = '0; m_bc = '0;
        m_rvalid = 0; m_rdata = '0; m_rtag = '0; m_busy = 0; m_ready = 1;
      end else begin : step
        int   size0;
        logic st_now, ld_next;
        req_t h, nr;
        ev_t  e;
        m_cyc++;
        size0 = mq.size();
        st_now = 0;
        m_rvalid = 0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].when == m_cyc) begin
            if (evq[i].is_ld) begin
              m_rvalid = 1; m_rdata = evq[i].data; m_rtag = evq[i].tag;
            end else begin
              m_bc = evq[i].data; mmem[int'(evq[i].addr)] = evq[i].data; st_now = 1;
            end
            evq.delete(i);
          end
        end
        if (size0 > 0) begin
          h = mq[0];
          if (!h.wr && m_add == h.addr && !(m_cslt && m_wrb)) begin
            m_cslt = 0; m_wrb = 0; m_add = ~h.addr;
          end else begin
            void'(mq.pop_front());
            m_cslt = 1; m_wrb = h.wr; m_add = h.addr;
            e.is_ld = !h.wr; e.addr = h.addr; e.tag = h.tag;
            e.when  = h.wr ? m_cyc + 1 : m_cyc + 2;
            e.data  = h.wr ? h.data : mread(h.addr);
            evq.push_back(e);
          end
        end else begin
          m_cslt = 0; m_wrb = 0;
        end
        if (bus.req_valid && size0 < DEPTH) begin
          nr.wr = bus.req_wr; nr.addr = bus.req_addr; nr.data = bus.req_wdata; nr.tag = bus.req_tag;
          mq.push_back(nr);
        end
        ld_next = 0;
        foreach (evq[i]) if (evq[i].is_ld && evq[i].when == m_cyc + 1) ld_next = 1;
        m_busy  = (mq.size() != 0) || m_cslt || st_now || ld_next;
        m_ready = (mq.size() < DEPTH);
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready",  32'(bus.req_ready),  32'(m_ready));
    check("busy",       32'(bus.busy),       32'(m_busy));
    check("ps_dm_cslt", 32'(bus.ps_dm_cslt), 32'(m_cslt));
    check("ps_dm_wrb",  32'(bus.ps_dm_wrb),  32'(m_wrb));
    check("dg_dm_add",  32'(bus.dg_dm_add),  32'(m_add));
    check("bc_dt",      32'(bus.bc_dt),      32'(m_bc));
    check("rsp_valid",  32'(bus.rsp_valid),  32'(m_rvalid));
    check("rsp_data",   32'(bus.rsp_data),   32'(m_rdata));
    check("rsp_tag",    32'(bus.rsp_tag),    32'(m_rtag));
  end

  task automatic drive(input logic v, input logic w, input logic [16:0] a,
                       input logic [15:0] d, input logic [3:0] t);
    bus.req_valid = v; bus.req_wr = w; bus.req_addr = a; bus.req_wdata = d; bus.req_tag = t;
  endtask

  task automatic idle_n(input int n);
    drive(0, 0, '0, '0, '0);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rsp(input string name, input logic [15:0] exp_d, input logic [3:0] exp_t);
    int i;
    for (i = 0; i < 12 && !bus.rsp_valid; i++) @(negedge clk);
    check({name, "_seen"}, 32'(bus.rsp_valid), 32'd1);
    check({name, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
    check({name, "_tag"},  32'(bus.rsp_tag),  32'(exp_t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int tag, k, run, max_run, nrsp, first_d;
    logic full_seen;
    drive(0, 0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_cslt",  32'(bus.ps_dm_cslt), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle_n(2);

    // single store, then a load of the same word
    drive(1, 1, 17'h0000A, 16'hFFEE, 4'd0);
    @(negedge clk); drive(0, 0, '0, '0, '0);
    @(negedge clk);
    check("st_cslt", 32'(bus.ps_dm_cslt), 32'd1);
    check("st_wrb",  32'(bus.ps_dm_wrb),  32'd1);
    check("st_add",  32'(bus.dg_dm_add),  32'h0000A);
    @(negedge clk);
    check("st_bc_dt", 32'(bus.bc_dt), 32'hFFEE);
    idle_n(3);
    drive(1, 0, 17'h0000A, '0, 4'd5);
    @(negedge clk); drive(0, 0, '0, '0, '0);
    wait_rsp("ld_after_st", 16'hFFEE, 4'd5);
    idle_n(4);

    // store then load to the same address, back to back
    drive(1, 1, 17'h0000F, 16'h1234, 4'd1);
    @(negedge clk); drive(1, 0, 17'h0000F, '0, 4'd2);
    @(negedge clk); drive(0, 0, '0, '0, '0);
    check("sl_st_cslt", 32'(bus.ps_dm_cslt), 32'd1);
    check("sl_st_wrb",  32'(bus.ps_dm_wrb),  32'd1);
    @(negedge clk);
    check("sl_ld_cslt", 32'(bus.ps_dm_cslt), 32'd1);
    check("sl_ld_wrb",  32'(bus.ps_dm_wrb),  32'd0);
    @(negedge clk); @(negedge clk);
    check("sl_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("sl_rsp_data",  32'(bus.rsp_data),  32'h1234);
    check("sl_rsp_tag",   32'(bus.rsp_tag),   32'd2);
    idle_n(4);

    // load then load to the same address: one bubble with inverted address
    drive(1, 0, 17'h00003, '0, 4'd3);
    @(negedge clk); drive(1, 0, 17'h00003, '0, 4'd4);
    @(negedge clk); drive(0, 0, '0, '0, '0);
    check("ll_i1_add", 32'(bus.dg_dm_add), 32'h00003);
    @(negedge clk);
    check("ll_bub_cslt", 32'(bus.ps_dm_cslt), 32'd0);
    check("ll_bub_add",  32'(bus.dg_dm_add),  32'h1FFFC);
    @(negedge clk);
    check("ll_i2_cslt", 32'(bus.ps_dm_cslt), 32'd1);
    check("ll_r1_data", 32'(bus.rsp_data), 32'hA603);
    check("ll_r1_tag",  32'(bus.rsp_tag),  32'd3);
    @(negedge clk); @(negedge clk);
    check("ll_r2_valid", 32'(bus.rsp_valid), 32'd1);
    check("ll_r2_data",  32'(bus.rsp_data),  32'hA603);
    idle_n(4);

    // fill the queue with guarded loads; a push while full is dropped
    tag = 0; k = 0; full_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        check("fill_tag_order", 32'(bus.rsp_tag), 32'(k));
        k++;
      end
      if (!full_seen && !bus.req_ready) begin
        full_seen = 1;
        drive(1, 0, 17'h00005, '0, 4'd15);
      end else if (!full_seen && i < 16) begin
        drive(1, 0, 17'h00005, '0, 4'(tag));
        tag++;
      end else begin
        drive(0, 0, '0, '0, '0);
      end
    end
    check("fill_full_seen", 32'(full_seen), 32'd1);
    check("fill_rsp_count", 32'(k), 32'(tag));

    // streaming alternating stores and loads to distinct addresses
    run = 0; max_run = 0; nrsp = 0; first_d = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.ps_dm_cslt) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (bus.rsp_valid) begin
        if (nrsp == 0) first_d = int'(bus.rsp_data);
        nrsp++;
      end
      if (i < 8) drive(1, i[0] == 1'b0, 17'h00100 + 17'(i), 16'h1000 + 16'(i), 4'(i));
      else drive(0, 0, '0, '0, '0);
    end
    check("stream_run", 32'(max_run), 32'd8);
    check("stream_rsps", 32'(nrsp), 32'd4);
    check("stream_first_data", 32'(first_d), 32'hA401);
    check("stream_idle_busy", 32'(bus.busy), 32'd0);

    // asynchronous reset with queued loads and one load in flight
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1, 0, 17'h00007, '0, 4'(i));
    end
    @(negedge clk); drive(0, 0, '0, '0, '0);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.req_ready), 32'd1);
    check("arst_cslt",  32'(bus.ps_dm_cslt), 32'd0);
    check("arst_add",   32'(bus.dg_dm_add), 32'd0);
    check("arst_bc_dt", 32'(bus.bc_dt), 32'd0);
    check("arst_busy",  32'(bus.busy), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
    check("post_rst_no_rsp", 32'(nrsp), 32'd0);
    drive(1, 0, 17'h00040, '0, 4'd6);
    @(negedge clk); drive(0, 0, '0, '0, '0);
    @(negedge clk);
    check("post_rst_cslt", 32'(bus.ps_dm_cslt), 32'd1);
    check("post_rst_add",  32'(bus.dg_dm_add), 32'h00040);
    idle_n(4);

    // randomised traffic over a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 1'($urandom), 17'($urandom_range(0, 7)),
            16'($urandom), 4'($urandom));
      @(negedge clk);
    end
    idle_n(20);
    check("final_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
